// File: rtl/bf16_result_sink.sv
// Result sink for the bf16 operation units: captures STB/BUSY handshaked results
// into a small FIFO and answers single-cycle CPU read requests one cycle later.
module bf16_result_sink #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_STB,
    output logic              in_BUSY,
    input  logic              flush,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    output logic [CNT_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    typedef enum logic {IDLE, RESP} rd_state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  level_next;
    logic              wr_en, rd_en;
    rd_state_t         state;

    // flush wins over both sides; a read on an empty FIFO is answered but moves nothing
    assign wr_en = in_STB & ~in_BUSY & ~flush;
    assign rd_en = rd_req & (level != '0) & ~flush;

    always_comb begin
        level_next = level;
        if (flush)
            level_next = '0;
        else if (wr_en & ~rd_en)
            level_next = level + 1'b1;
        else if (rd_en & ~wr_en)
            level_next = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_result;
    end

    // BUSY held high through reset so no transfer lands before the first clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            in_BUSY <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            end
            level   <= level_next;
            in_BUSY <= (level_next == FULL_LVL) | flush;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rd_data  <= '0;
            rd_empty <= 1'b0;
        end else if (rd_req) begin
            state    <= RESP;
            rd_data  <= rd_en ? mem[rd_ptr] : '0;
            rd_empty <= ~rd_en;
        end else begin
            state    <= IDLE;
            rd_data  <= '0;
            rd_empty <= 1'b0;
        end
    end

    assign rd_valid = (state == RESP);

endmodule
